fp_addsub_seq: RTL

Multi-cycle IEEE-754 single-precision add/subtract sequencer for the FPU.
- Unpacks operands, orders them by magnitude, then steps through align, add and normalize, one mantissa bit per cycle.
- Mantissa subtraction goes through the existing 24-bit twoscomp negator feeding a 24-bit adder.
- Intended as the low-area add/sub path beside the rest of the FPU datapath.

---
 rtl/fp_addsub_seq.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle IEEE-754 single-precision add/subtract sequencer.
// Aligns one bit per cycle, adds (or subtracts via two's complement of the
// smaller mantissa), normalizes one bit per cycle, truncating throughout.
module fp_addsub_seq #(
  parameter int unsigned ALIGN_LIMIT = 25
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        OP,
  input  logic        START,
  output logic [31:0] RESULT,
  output logic        DONE,
  output logic        BUSY
);

  localparam int unsigned MAN_W = 24;
  localparam int unsigned EXP_W = 8;
  localparam int unsigned CNT_W = $clog2(ALIGN_LIMIT);

  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    IDLE,
    ALIGN,
    ADD,
    NORM,
    FIN
  } state_t;

  state_t             state;
  logic [MAN_W-1:0]   man_big;
  logic [MAN_W-1:0]   man_small;
  logic [EXP_W-1:0]   exp_r;
  logic [CNT_W-1:0]   count;
  logic               sign_r;
  logic               sub_r;
  logic               inf_r;

  // Operand unpack and magnitude ordering, used only when START is accepted
  logic [EXP_W-1:0]   exp_a;
  logic [EXP_W-1:0]   exp_b;
  logic [MAN_W-1:0]   man_a;
  logic [MAN_W-1:0]   man_b;
  logic               sign_b_eff;
  logic               a_is_big;
  logic [EXP_W-1:0]   exp_big_c;
  logic [EXP_W-1:0]   exp_small_c;
  logic [MAN_W-1:0]   man_big_c;
  logic [MAN_W-1:0]   man_small_c;
  logic               sign_big_c;
  logic [EXP_W-1:0]   diff_c;
  logic               special_c;

  always_comb begin
    exp_a       = A[30:23];
    exp_b       = B[30:23];
    man_a       = (exp_a == '0) ? '0 : {1'b1, A[22:0]};
    man_b       = (exp_b == '0) ? '0 : {1'b1, B[22:0]};
    sign_b_eff  = B[31] ^ OP;
    a_is_big    = ({exp_a, man_a} >= {exp_b, man_b});
    exp_big_c   = a_is_big ? exp_a : exp_b;
    exp_small_c = a_is_big ? exp_b : exp_a;
    man_big_c   = a_is_big ? man_a : man_b;
    man_small_c = a_is_big ? man_b : man_a;
    sign_big_c  = a_is_big ? A[31] : sign_b_eff;
    diff_c      = exp_big_c - exp_small_c;
    special_c   = (exp_a == '1) || (exp_b == '1);
  end

  // Mantissa adder and the two's complement negator for subtraction
  logic [MAN_W:0]     sum_add;
  logic [MAN_W-1:0]   neg_small;
  logic [MAN_W-1:0]   sum_sub;

  always_comb begin
    neg_small = ~man_small + MAN_W'(1);
    sum_add   = (MAN_W+1)'(man_big) + (MAN_W+1)'(man_small);
    sum_sub   = man_big + neg_small;
  end

  // Sequencer: state, datapath registers and registered outputs
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state     <= IDLE;
      man_big   <= '0;
      man_small <= '0;
      exp_r     <= '0;
      count     <= '0;
      sign_r    <= 1'b0;
      sub_r     <= 1'b0;
      inf_r     <= 1'b0;
      RESULT    <= '0;
      DONE      <= 1'b0;
      BUSY      <= 1'b0;
    end else begin
      DONE <= 1'b0;
      case (state)
        IDLE: begin
          if (START) begin
            BUSY <= 1'b1;
            if (special_c) begin
              RESULT <= QNAN;
              DONE   <= 1'b1;
              state  <= FIN;
            end else begin
              man_big <= man_big_c;
              exp_r   <= exp_big_c;
              sign_r  <= sign_big_c;
              sub_r   <= A[31] ^ B[31] ^ OP;
              inf_r   <= 1'b0;
              if (32'(diff_c) >= ALIGN_LIMIT) begin
                man_small <= '0;
                count     <= '0;
              end else begin
                man_small <= man_small_c;
                count     <= CNT_W'(diff_c);
              end
              state <= ALIGN;
            end
          end
        end

        ALIGN: begin
          if (count != '0) begin
            man_small <= man_small >> 1;
            count     <= count - CNT_W'(1);
          end else begin
            state <= ADD;
          end
        end

        ADD: begin
          if (sub_r) begin
            man_big <= sum_sub;
          end else if (sum_add[MAN_W]) begin
            man_big <= sum_add[MAN_W:1];
            exp_r   <= exp_r + EXP_W'(1);
            if (exp_r == 8'd254) inf_r <= 1'b1;
          end else begin
            man_big <= sum_add[MAN_W-1:0];
          end
          state <= NORM;
        end

        NORM: begin
          if (inf_r) begin
            RESULT <= {sign_r, 8'hFF, 23'd0};
            DONE   <= 1'b1;
            state  <= FIN;
          end else if (man_big == '0) begin
            RESULT <= '0;
            DONE   <= 1'b1;
            state  <= FIN;
          end else if (man_big[MAN_W-1]) begin
            RESULT <= {sign_r, exp_r, man_big[22:0]};
            DONE   <= 1'b1;
            state  <= FIN;
          end else if (exp_r <= 8'd1) begin
            // another shift would underflow the exponent: flush to signed zero
            RESULT <= {sign_r, 31'd0};
            DONE   <= 1'b1;
            state  <= FIN;
          end else begin
            man_big <= man_big << 1;
            exp_r   <= exp_r - EXP_W'(1);
          end
        end

        FIN: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end

        default: begin
          BUSY  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
